// File: rtl/mem_2ps_mrd.sv
// mem_2ps_mrd: simple dual-port memory with one write port and NUM_RD
// registered read ports, each with a valid strobe.
//
// After reset, an internal sweep writes INIT_VALUE to every entry, one entry
// per cycle. Ports are accepted only once ready_o is high.
//
// Optional feature, controlled by the macro MEM_BYPASS_EN:
//   - defined:   a read and a write to the same address in the same cycle
//                return the new write data (write-first).
//   - undefined: that read returns the pre-write contents (read-first).
module mem_2ps_mrd #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_RD     = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           ready_o,
    input  logic                           write_en_i,
    input  logic [ADDR_WIDTH-1:0]          addr_write_i,
    input  logic [DATA_WIDTH-1:0]          data_write_i,
    input  logic [NUM_RD-1:0]              rd_en_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   addr_read_i,
    output logic [NUM_RD*DATA_WIDTH-1:0]   data_read_o,
    output logic [NUM_RD-1:0]              rd_valid_o
);

    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           init_cnt_q, init_cnt_d;
    logic [NUM_RD-1:0]               rd_valid_q, rd_valid_d;
    logic [NUM_RD*DATA_WIDTH-1:0]    data_read_q, data_read_d;

    logic [DATA_WIDTH-1:0]           mem [MEM_DEPTH];

    logic                            mem_we;
    logic [ADDR_WIDTH-1:0]           mem_waddr;
    logic [DATA_WIDTH-1:0]           mem_wdata;

    // Init sweep counter and state progression; READY is left only by reset.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
                    state_d    = ST_READY;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d    = ST_READY;
                init_cnt_d = init_cnt_q;
            end
        endcase
    end

    // Single write path shared by the init sweep and the user write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_cnt_q;
        mem_wdata = INIT_VALUE;
        if (rst_n) begin
            if (state_q == ST_INIT) begin
                mem_we = 1'b1;
            end else if (write_en_i) begin
                mem_we    = 1'b1;
                mem_waddr = addr_write_i;
                mem_wdata = data_write_i;
            end
        end
    end

    // Per-port read capture; data holds when a port is idle.
    always_comb begin
        rd_valid_d  = '0;
        data_read_d = data_read_q;
        if (state_q == ST_READY) begin
            for (int k = 0; k < NUM_RD; k++) begin
                if (rd_en_i[k]) begin
                    rd_valid_d[k] = 1'b1;
`ifdef MEM_BYPASS_EN
                    if (mem_we && (mem_waddr == addr_read_i[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                        data_read_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_wdata;
                    end else begin
                        data_read_d[k*DATA_WIDTH +: DATA_WIDTH] =
                            mem[addr_read_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
                    end
`else
                    data_read_d[k*DATA_WIDTH +: DATA_WIDTH] =
                        mem[addr_read_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
`endif
                end
            end
        end
    end

    // Control and read-port registers; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            rd_valid_q  <= '0;
            data_read_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rd_valid_q  <= rd_valid_d;
            data_read_q <= data_read_d;
        end
    end

    // Storage array; not reset, the init sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ready_o     = (state_q == ST_READY);
    assign rd_valid_o  = rd_valid_q;
    assign data_read_o = data_read_q;

endmodule
